// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Stall polarity, zero word and bus widths live here so every user agrees on them.
package inst_fetch_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic                   STOP      = 1'b1;
   localparam logic                   NO_STOP   = 1'b0;
   localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic [2:0] {
      IF_IDLE   = 3'd0,
      IF_REQ    = 3'd1,
      IF_WAIT   = 3'd2,
      IF_HOLD   = 3'd3,
      IF_CANCEL = 3'd4
   } if_state_e;

   function automatic logic pc_misaligned(input logic [INST_ADDR_W-1:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// IF stage: fetches one instruction at a time over a req/addr_ok/data_ok bus and holds it for decode.
// Optional INST_FETCH_ALIGN_CHK_EN: misaligned PCs skip the bus and deliver a NOP with o_excp_adel set.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             stall,
   input  logic                   flush,
   input  logic [INST_ADDR_W-1:0] pc_i,
   output logic                   inst_req,
   output logic [INST_ADDR_W-1:0] inst_addr,
   input  logic                   inst_addr_ok,
   input  logic                   inst_data_ok,
   input  logic [INST_W-1:0]      inst_rdata,
   output logic [INST_ADDR_W-1:0] o_pc,
   output logic [INST_W-1:0]      o_inst,
   output logic                   o_valid,
   output logic                   o_excp_adel,
   output logic                   stallreq
);

   if_state_e              state, state_nxt;
   logic [INST_ADDR_W-1:0] req_pc, req_pc_nxt;
   logic [INST_ADDR_W-1:0] pc_nxt;
   logic [INST_W-1:0]      inst_nxt;
   logic                   valid_nxt;
   logic                   excp_nxt;
   logic                   start;
   logic                   if_stop;

   // Only stall[1] concerns this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[5:2], stall[0]};
   assign if_stop      = (stall[1] == STOP);

   always_comb begin
      state_nxt  = state;
      req_pc_nxt = req_pc;
      pc_nxt     = o_pc;
      inst_nxt   = o_inst;
      valid_nxt  = o_valid;
      excp_nxt   = o_excp_adel;
      start      = 1'b0;

      case (state)
         IF_IDLE: begin
            if (!flush && !if_stop) start = 1'b1;
         end
         IF_REQ: begin
            if (inst_addr_ok)  state_nxt = flush ? IF_CANCEL : IF_WAIT;
            else if (flush)    state_nxt = IF_IDLE;
         end
         IF_WAIT: begin
            if (flush) begin
               // Data landing together with the flush is simply dropped.
               state_nxt = inst_data_ok ? IF_IDLE : IF_CANCEL;
            end else if (inst_data_ok) begin
               state_nxt = IF_HOLD;
               pc_nxt    = req_pc;
               inst_nxt  = inst_rdata;
               valid_nxt = 1'b1;
               excp_nxt  = 1'b0;
            end
         end
         IF_HOLD: begin
            if (flush || !if_stop) begin
               state_nxt = IF_IDLE;
               inst_nxt  = NOP_INST;
               valid_nxt = 1'b0;
               excp_nxt  = 1'b0;
               start     = !flush;
            end
         end
         IF_CANCEL: begin
            if (inst_data_ok) state_nxt = IF_IDLE;
         end
         default: state_nxt = IF_IDLE;
      endcase

      if (start) begin
`ifdef INST_FETCH_ALIGN_CHK_EN
         if (pc_misaligned(pc_i)) begin
            state_nxt = IF_HOLD;
            pc_nxt    = pc_i;
            inst_nxt  = NOP_INST;
            valid_nxt = 1'b1;
            excp_nxt  = 1'b1;
         end else begin
            state_nxt  = IF_REQ;
            req_pc_nxt = pc_i;
         end
`else
         state_nxt  = IF_REQ;
         req_pc_nxt = pc_i;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IF_IDLE;
         req_pc  <= ZERO_WORD;
         o_pc    <= ZERO_WORD;
         o_inst  <= NOP_INST;
         o_valid <= 1'b0;
      end else begin
         state   <= state_nxt;
         req_pc  <= req_pc_nxt;
         o_pc    <= pc_nxt;
         o_inst  <= inst_nxt;
         o_valid <= valid_nxt;
      end
   end

`ifdef INST_FETCH_ALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (reset) o_excp_adel <= 1'b0;
      else       o_excp_adel <= excp_nxt;
   end
   assign inst_addr = (state == IF_REQ) ? req_pc : ZERO_WORD;
`else
   logic unused_excp;
   assign unused_excp = excp_nxt;
   assign o_excp_adel = 1'b0;
   assign inst_addr   = (state == IF_REQ) ? {req_pc[31:2], 2'b00} : ZERO_WORD;
`endif

   // The bus sees a request only in REQ; the pipeline is held until data returns or is cancelled.
   assign inst_req = (state == IF_REQ);
   assign stallreq = (state == IF_REQ) || (state == IF_WAIT);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a transaction-level reference model checked every cycle.
// Build with INST_FETCH_ALIGN_CHK_EN defined to exercise the misaligned-PC path.
module tb_inst_fetch;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] pc_i;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_valid;
   logic        o_excp_adel;
   logic        stallreq;

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   inst_fetch #(.NOP_INST(NOP)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_i(pc_i),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .o_pc(o_pc),
      .o_inst(o_inst), .o_valid(o_valid), .o_excp_adel(o_excp_adel), .stallreq(stallreq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: facts about the single fetch transaction rather than a state register.
   logic        m_req   = 1'b0;   // request on the bus, not yet accepted
   logic        m_fly   = 1'b0;   // accepted, data still to come
   logic        m_drop  = 1'b0;   // in-flight data must be discarded
   logic [31:0] m_addr  = '0;
   logic        m_valid = 1'b0;
   logic [31:0] m_pc    = '0;
   logic [31:0] m_inst  = NOP;
   logic        m_excp  = 1'b0;

   task automatic deliver(input logic [31:0] pc, input logic [31:0] inst, input logic ex);
      m_valid <= 1'b1;
      m_pc    <= pc;
      m_inst  <= inst;
      m_excp  <= ex;
   endtask

   task automatic retire();
      m_valid <= 1'b0;
      m_inst  <= NOP;
      m_excp  <= 1'b0;
   endtask

   task automatic begin_fetch(input logic [31:0] pc);
`ifdef INST_FETCH_ALIGN_CHK_EN
      if (pc[1:0] != 2'b00) deliver(pc, NOP, 1'b1);
      else begin
         m_req  <= 1'b1;
         m_addr <= pc;
      end
`else
      m_req  <= 1'b1;
      m_addr <= pc;
`endif
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_req <= 1'b0; m_fly <= 1'b0; m_drop <= 1'b0; m_addr <= '0;
         m_valid <= 1'b0; m_pc <= '0; m_inst <= NOP; m_excp <= 1'b0;
      end else if (m_req) begin
         if (inst_addr_ok) begin
            m_req <= 1'b0; m_fly <= 1'b1; m_drop <= flush;
         end else if (flush) m_req <= 1'b0;
      end else if (m_fly) begin
         if (inst_data_ok) begin
            m_fly  <= 1'b0;
            m_drop <= 1'b0;
            if (!m_drop && !flush) deliver(m_addr, inst_rdata, 1'b0);
         end else if (flush) m_drop <= 1'b1;
      end else if (m_valid) begin
         if (flush) retire();
         else if (!stall[1]) begin
            retire();
            begin_fetch(pc_i);
         end
      end else if (!flush && !stall[1]) begin_fetch(pc_i);
   end

   logic [31:0] exp_addr;
`ifdef INST_FETCH_ALIGN_CHK_EN
   assign exp_addr = m_addr;
`else
   assign exp_addr = {m_addr[31:2], 2'b00};
`endif

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("inst_req", {31'b0, inst_req}, {31'b0, m_req});
         chk("stallreq", {31'b0, stallreq}, {31'b0, m_req || (m_fly && !m_drop)});
         chk("inst_addr", inst_addr, m_req ? exp_addr : 32'h0);
         chk("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
         chk("o_inst", o_inst, m_inst);
         chk("o_excp_adel", {31'b0, o_excp_adel}, {31'b0, m_excp});
         if (m_valid) chk("o_pc", o_pc, m_pc);
      end
   end

   task automatic step(input logic s1, input logic fl, input logic aok, input logic dok,
                       input logic [31:0] rd);
      stall        = {4'b0, s1, 1'b0};
      flush        = fl;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; pc_i = 32'h0; stall = '0; flush = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
      step(0, 0, 0, 0, 0);
      cmp_en = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_req", {31'b0, inst_req}, 32'd0);
      chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
      chk("rst_inst", o_inst, NOP);
      chk("rst_addr", inst_addr, 32'h0);

      // Reset release and first fetch
      reset = 1'b0; pc_i = 32'hBFC0_0000;
      step(0, 0, 1, 0, 0);
      chk("t1_req", {31'b0, inst_req}, 32'd1);
      chk("t1_addr", inst_addr, 32'hBFC0_0000);
      step(0, 0, 1, 0, 0);
      chk("t1_wait_stall", {31'b0, stallreq}, 32'd1);
      step(0, 0, 0, 1, 32'h2408_0001);
      chk("t1_valid", {31'b0, o_valid}, 32'd1);
      chk("t1_pc", o_pc, 32'hBFC0_0000);
      chk("t1_inst", o_inst, 32'h2408_0001);

      // Held by decode stall, then released
      pc_i = 32'hBFC0_0004;
      repeat (4) step(1, 0, 0, 0, 0);
      chk("t2_hold_inst", o_inst, 32'h2408_0001);
      chk("t2_hold_req", {31'b0, inst_req}, 32'd0);
      step(0, 0, 0, 0, 0);
      chk("t2_req", {31'b0, inst_req}, 32'd1);
      chk("t2_addr", inst_addr, 32'hBFC0_0004);
      chk("t2_valid0", {31'b0, o_valid}, 32'd0);
      step(0, 0, 1, 0, 0);

      // Flush in WAIT, data returns later and is swallowed
      step(0, 1, 0, 0, 0);
      chk("t3_cancel_stall", {31'b0, stallreq}, 32'd0);
      pc_i = 32'hBFC0_0100;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'hDEAD_BEEF);
      chk("t3_no_valid", {31'b0, o_valid}, 32'd0);
      step(0, 0, 0, 0, 0);
      chk("t3_addr", inst_addr, 32'hBFC0_0100);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 32'h3C1D_0010);
      chk("t3_pc", o_pc, 32'hBFC0_0100);
      chk("t3_inst", o_inst, 32'h3C1D_0010);

      // Flush together with data_ok
      pc_i = 32'hBFC0_0104;
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 1, 0, 1, 32'hAAAA_5555);
      chk("t4_stallreq", {31'b0, stallreq}, 32'd0);
      chk("t4_valid", {31'b0, o_valid}, 32'd0);

      // Bus holds addr_ok low
      pc_i = 32'hBFC0_0200;
      step(0, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0);
      chk("t5_req", {31'b0, inst_req}, 32'd1);
      chk("t5_addr", inst_addr, 32'hBFC0_0200);
      chk("t5_stall", {31'b0, stallreq}, 32'd1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 32'h1234_5678);
      chk("t5_inst", o_inst, 32'h1234_5678);

      // Flush beats stall in HOLD, idle respects stall, flush in REQ both ways
      pc_i = 32'hBFC0_0300;
      step(1, 1, 0, 0, 0);
      chk("fl_hold_valid", {31'b0, o_valid}, 32'd0);
      step(1, 0, 0, 0, 0);
      chk("idle_stall_req", {31'b0, inst_req}, 32'd0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("fl_req_idle", {31'b0, inst_req | stallreq}, 32'd0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("fl_req_cancel", {31'b0, stallreq}, 32'd0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h5555_AAAA);
      chk("cancel_drop", {31'b0, o_valid}, 32'd0);

      // Reset mid-transaction; stale data_ok afterwards is ignored
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      reset = 1'b0;
      step(1, 0, 0, 1, 32'hCAFE_F00D);
      chk("rst_mid_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_mid_req", {31'b0, inst_req}, 32'd0);
      pc_i = 32'hBFC0_0400;
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 32'h0BAD_C0DE);
      chk("rst_mid_pc", o_pc, 32'hBFC0_0400);

      // Misaligned PC
      step(1, 1, 0, 0, 0);
      pc_i = 32'hBFC0_0002;
      step(0, 0, 0, 0, 0);
`ifdef INST_FETCH_ALIGN_CHK_EN
      chk("t6_req", {31'b0, inst_req}, 32'd0);
      chk("t6_excp", {31'b0, o_excp_adel}, 32'd1);
      chk("t6_inst", o_inst, NOP);
      chk("t6_pc", o_pc, 32'hBFC0_0002);
      chk("t6_valid", {31'b0, o_valid}, 32'd1);
`else
      chk("mis_addr", inst_addr, 32'hBFC0_0000);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 32'h2000_0001);
      chk("mis_pc", o_pc, 32'hBFC0_0002);
      chk("mis_excp", {31'b0, o_excp_adel}, 32'd0);
`endif
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
